// File: rtl/shift_seq_unit_pkg.sv
// Shared ALU shifter definitions: operation encodings and the sequential shifter FSM states.
// The op codes are common to the combinational shifter and the ALU decoder.
package shift_seq_unit_pkg;

    localparam int SHIFT_WIDTH = 8;
    localparam int SHIFT_AMT_W = 3;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROL = 2'b11
    } shift_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } shift_state_e;

endpackage

// File: rtl/shift_seq_unit_step.sv
// Combinational one-bit shift step: next data word and the bit that leaves it.
// Matches the combinational shifter with an amount of 1.
module shift_step
    import shift_seq_unit_pkg::*;
#(
    parameter int WIDTH = SHIFT_WIDTH
) (
    input  logic [WIDTH-1:0] d_i,
    input  shift_op_e        op_i,
    output logic [WIDTH-1:0] d_next_o,
    output logic             carry_o
);

    always_comb begin
        d_next_o = d_i;
        carry_o  = 1'b0;
        unique case (op_i)
            SH_LSL: begin
                d_next_o = {d_i[WIDTH-2:0], 1'b0};
                carry_o  = d_i[WIDTH-1];
            end
            SH_LSR: begin
                d_next_o = {1'b0, d_i[WIDTH-1:1]};
                carry_o  = d_i[0];
            end
            SH_ASR: begin
                d_next_o = {d_i[WIDTH-1], d_i[WIDTH-1:1]};
                carry_o  = d_i[0];
            end
            SH_ROL: begin
                d_next_o = {d_i[WIDTH-2:0], d_i[WIDTH-1]};
                carry_o  = d_i[WIDTH-1];
            end
            default: begin
                d_next_o = d_i;
                carry_o  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/shift_seq_unit.sv
// Multi-cycle shifter: captures an operand on start, shifts one bit per clock,
// then pulses done for one cycle with the result and last bit shifted out.
module shift_seq_unit
    import shift_seq_unit_pkg::*;
#(
    parameter int WIDTH = SHIFT_WIDTH,
    parameter int AMT_W = SHIFT_AMT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [1:0]       shift_Sel,
    input  logic [AMT_W-1:0] amt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] shifter_Out,
    output logic             carry_out
);

    shift_state_e     state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    shift_op_e        op_q, op_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;

    logic [WIDTH-1:0] stepData;
    logic             stepCarry;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .d_i      (data_q),
        .op_i     (op_q),
        .d_next_o (stepData),
        .carry_o  (stepCarry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            op_q    <= SH_LSL;
            cnt_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    data_d  = A;
                    op_d    = shift_op_e'(shift_Sel);
                    cnt_d   = amt;
                    carry_d = 1'b0;
                    state_d = (amt != '0) ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                // The edge that applies the last shift also moves to DONE.
                data_d  = stepData;
                carry_d = stepCarry;
                cnt_d   = cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign shifter_Out = data_q;
    assign carry_out   = carry_q;

endmodule

// File: tb/tb_shift_seq_unit.sv
// Scoreboard bench for shift_seq_unit: stimulus pushes expected results,
// a monitor pops and compares them whenever done is seen.
module tb_shift_seq_unit;
    import shift_seq_unit_pkg::*;

    typedef struct {
        logic [7:0] res;
        logic       c;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] A;
    logic [1:0] shift_Sel;
    logic [2:0] amt;
    logic       busy;
    logic       done;
    logic [7:0] shifter_Out;
    logic       carry_out;

    int   vectors = 0;
    int   miscompares = 0;
    int   cycleCnt = 0;
    exp_t sbQ[$];
    exp_t monEntry;

    shift_seq_unit dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .A           (A),
        .shift_Sel   (shift_Sel),
        .amt         (amt),
        .busy        (busy),
        .done        (done),
        .shifter_Out (shifter_Out),
        .carry_out   (carry_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycleCnt);
        end
    endtask

    // Done pulses are matched in order against the queue, including the edge they appear on.
    always @(negedge clk) begin
        if (!rst && done === 1'b1) begin
            if (sbQ.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_done: got done=1 at cycle %0d, expected no pending operation", cycleCnt);
            end else begin
                monEntry = sbQ.pop_front();
                checkOutput("result", int'(shifter_Out), int'(monEntry.res));
                checkOutput("carry", int'(carry_out), int'(monEntry.c));
                checkOutput("done_cycle", cycleCnt, monEntry.cyc);
            end
        end
    end

    // Returns on the negedge after the accepting edge, with start already dropped.
    task automatic applyStimulus(input logic [7:0] a, input logic [1:0] sel, input logic [2:0] n,
                                 input logic [7:0] expRes, input logic expC);
        int waitCnt = 0;
        while (busy === 1'b1 && waitCnt < 40) begin
            @(negedge clk);
            waitCnt++;
        end
        if (busy !== 1'b0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL idle_timeout: got busy=%b, expected 0 within 40 cycles", busy);
        end
        A         = a;
        shift_Sel = sel;
        amt       = n;
        start     = 1'b1;
        sbQ.push_back('{res: expRes, c: expC, cyc: cycleCnt + 1 + int'(n)});
        @(negedge clk);
        start = 1'b0;
    endtask

    logic [7:0] asrSteps [3] = '{8'hFB, 8'hFD, 8'hFE};

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        A         = 8'h00;
        shift_Sel = 2'b00;
        amt       = 3'd0;
        #2;
        checkOutput("reset_out", int'(shifter_Out), 0);
        checkOutput("reset_carry", int'(carry_out), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_done", int'(done), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        applyStimulus(8'h0A, SH_LSL, 3'd1, 8'h14, 1'b0);
        checkOutput("busy_after_accept", int'(busy), 1);

        applyStimulus(8'hF6, SH_ASR, 3'd3, 8'hFE, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("asr_step", int'(shifter_Out), int'(asrSteps[i]));
            checkOutput("asr_busy", int'(busy), 1);
        end

        applyStimulus(8'h81, SH_ROL, 3'd1, 8'h03, 1'b1);

        applyStimulus(8'h0A, SH_LSR, 3'd0, 8'h0A, 1'b0);
        checkOutput("amt0_done", int'(done), 1);

        applyStimulus(8'h0F, SH_LSL, 3'd7, 8'h80, 1'b1);
        @(negedge clk);
        @(negedge clk);
        A     = 8'hFF;
        amt   = 3'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        applyStimulus(8'h33, SH_LSL, 3'd5, 8'h00, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checkOutput("abort_out", int'(shifter_Out), 0);
        checkOutput("abort_carry", int'(carry_out), 0);
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_done", int'(done), 0);
        void'(sbQ.pop_back());
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("idle_after_abort", int'(busy), 0);

        applyStimulus(8'h01, SH_LSL, 3'd2, 8'h04, 1'b0);

        // Start held high: accepts every 4 cycles with a single idle cycle between.
        while (busy === 1'b1) @(negedge clk);
        A         = 8'h11;
        shift_Sel = SH_LSR;
        amt       = 3'd2;
        start     = 1'b1;
        for (int j = 0; j < 3; j++) begin
            sbQ.push_back('{res: 8'h04, c: 1'b0, cyc: cycleCnt + 1 + 2 + 4 * j});
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checkOutput("held_busy", int'(busy), (i % 4 == 3) ? 0 : 1);
        end
        start = 1'b0;

        for (int t = 0; t < 100 && sbQ.size() != 0; t++) @(negedge clk);
        repeat (3) @(negedge clk);
        checkOutput("queue_drained", sbQ.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
